serial_alu_ctrl: RTL and testbench

// Bit-serial sequencer for the shared 1-bit full-adder cell in the ALU datapath.

---
 rtl/serial_alu_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_alu_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// ============================================================================
//  Module   : serial_alu_ctrl
//  Summary  : Bit-serial ADD/SUB sequencer driving an external 1-bit full adder.
//             Optional signed-overflow output enabled by SERIAL_ALU_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_cin,
   input  logic             cell_out,
   input  logic             cell_cout
`ifdef SERIAL_ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      cell_a   = 1'b0;
      cell_b   = 1'b0;
      cell_cin = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // SUB is a + ~b + 1: invert B here and seed the carry with op
               state_d = S_RUN;
               a_d     = a;
               b_d     = b ^ {WIDTH{op}};
               carry_d = op;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cell_a   = a_q[0];
            cell_b   = b_q[0];
            cell_cin = carry_q;
            carry_d  = cell_cout;
            res_d    = {cell_out, res_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == C_LAST_BIT) begin
               // carry_q is the carry into the MSB on this final bit
               cout_d  = cell_cout;
               ovf_d   = carry_q ^ cell_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = res_q;
   assign cout   = cout_q;

`ifdef SERIAL_ALU_OVF_EN
   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
// ============================================================================
//  Module   : tb_serial_alu_ctrl
//  Summary  : Directed, table-driven self-checking bench for serial_alu_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         cell_a;
   logic         cell_b;
   logic         cell_cin;
   logic         cell_out;
   logic         cell_cout;
`ifdef SERIAL_ALU_OVF_EN
   logic         ovf;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // Behavioural full-adder cell
   assign cell_out  = cell_a ^ cell_b ^ cell_cin;
   assign cell_cout = (cell_a & cell_b) | (cell_cin & (cell_a ^ cell_b));

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .cout      (cout),
      .cell_a    (cell_a),
      .cell_b    (cell_b),
      .cell_cin  (cell_cin),
      .cell_out  (cell_out),
      .cell_cout (cell_cout)
`ifdef SERIAL_ALU_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Issue one op, return cycles-to-done (0 on timeout), carry-in of the first
   // RUN cycle, and whether busy stayed high throughout.
   task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output logic cin0, output logic busy_ok);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = ~o; a = ~x; b = ~y;
      lat = 0; busy_ok = 1'b1; cin0 = 1'bx;
      for (int n = 1; n <= 40; n++) begin
         if (n == 1) cin0 = cell_cin;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            cyc = n;
            break;
         end
      end
   endtask

   initial begin
      int   lat;
      int   ndone;
      logic cin0;
      logic busy_ok;

      //          op    a      b      res    cout  ovf
      vecs[0]  = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 8'h10, 8'h10, 8'h20, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {busy, done, result, cout, cell_a, cell_b, cell_cin}, 32'h0);
`ifdef SERIAL_ALU_OVF_EN
      chk("reset_ovf", ovf, 0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, cin0, busy_ok);
         chk($sformatf("v%0d_latency", i), lat, W + 1);
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_cout", i), cout, vecs[i].cout);
         chk($sformatf("v%0d_first_cin", i), cin0, vecs[i].op);
         chk($sformatf("v%0d_busy_run", i), busy_ok, 1);
`ifdef SERIAL_ALU_OVF_EN
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
`endif
         @(negedge clk);
         chk($sformatf("v%0d_idle_after", i), {busy, done, cell_a, cell_b, cell_cin}, 0);
         chk($sformatf("v%0d_result_hold", i), result, vecs[i].res);
      end

      // start pulsed mid-RUN must be ignored
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 8'h3C; b = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk("ign_latency", lat + 4, W + 1);
      chk("ign_result", result, 8'h4B);
      ndone = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("ign_no_second_done", ndone, 0);
      chk("ign_busy_low", busy, 0);

      // Reset in the middle of RUN discards the operation
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 8'h55; b = 8'h33;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy_before_rst", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs", {busy, done, result, cout, cell_a, cell_b, cell_cin}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b0, 8'h01, 8'h01, lat, cin0, busy_ok);
      chk("post_rst_latency", lat, W + 1);
      chk("post_rst_result", result, 8'h02);

      // start held high: back-to-back ops, one per WIDTH+2 cycles
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 8'h01; b = 8'h02;
      wait_done(lat);
      chk("held_first_latency", lat, W + 1);
      wait_done(lat);
      start = 1'b0;
      chk("held_throughput", lat, W + 2);
      chk("held_result", result, 8'h03);
      repeat (W + 4) @(negedge clk);
      chk("held_release_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
